// File: rtl/out_drain_sched.sv
// out_drain_sched: drains WPC words from each of NCOL column controllers,
// round-robin, onto a single valid/ready writeback port at base + col*WPC + word.
module out_drain_sched #(
    parameter int NCOL = 4,
    parameter int DW   = 32,
    parameter int AW   = 16,
    parameter int WPC  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [NCOL-1:0]     col_rvalid,
    input  logic [DW-1:0]       col_data [NCOL],
    output logic [NCOL-1:0]     col_rread,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [AW-1:0]       wr_addr,
    output logic [DW-1:0]       wr_data,
    output logic                busy,
    output logic                done
);
    localparam int CW = $clog2(WPC + 1);
    localparam int RW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [1:0] IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2, DONE = 2'd3;

    logic [1:0]      r_state;
    logic [AW-1:0]   r_base, r_addr;
    logic [DW-1:0]   r_data;
    logic            r_valid;
    logic [CW-1:0]   r_cnt [NCOL];
    logic [RW-1:0]   r_rr, r_g;
    logic [NCOL-1:0] w_elig;
    logic [RW-1:0]   w_hi, w_lo, w_gnt;
    logic            w_any_hi, w_last;
    logic [AW-1:0]   w_addr;

    always_comb begin
        w_elig = '0;
        for (int c = 0; c < NCOL; c++)
            w_elig[c] = col_rvalid[c] && (r_cnt[c] < CW'(WPC));
    end

    // Scanning downward leaves the lowest eligible index: w_hi at/after rr, w_lo overall (wrap case).
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        w_any_hi = 1'b0;
        w_last = 1'b1;
        for (int c = NCOL - 1; c >= 0; c--) begin
            if (w_elig[c]) w_lo = RW'(c);
            if (w_elig[c] && RW'(c) >= r_rr) begin
                w_hi = RW'(c);
                w_any_hi = 1'b1;
            end
            if (((RW'(c) == r_g) ? r_cnt[c] + 1'b1 : r_cnt[c]) != CW'(WPC)) w_last = 1'b0;
        end
    end

    assign w_gnt     = w_any_hi ? w_hi : w_lo;
    assign w_addr    = r_base + AW'(w_gnt) * AW'(WPC) + AW'(r_cnt[w_gnt]);
    assign col_rread = (r_state == ARB && |w_elig) ? NCOL'(1) << w_gnt : '0;
    assign wr_valid  = r_valid;
    assign wr_addr   = r_addr;
    assign wr_data   = r_data;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_rr    <= '0;
            r_g     <= '0;
            for (int c = 0; c < NCOL; c++) r_cnt[c] <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_base  <= base_addr;
                    r_rr    <= '0;
                    for (int c = 0; c < NCOL; c++) r_cnt[c] <= '0;
                    r_state <= ARB;
                end
                ARB: if (|w_elig) begin
                    r_g     <= w_gnt;
                    r_data  <= col_data[w_gnt];
                    r_addr  <= w_addr;
                    r_valid <= 1'b1;
                    r_state <= XFER;
                end
                XFER: if (wr_ready) begin
                    r_cnt[r_g] <= r_cnt[r_g] + 1'b1;
                    r_rr       <= (r_g == RW'(NCOL - 1)) ? '0 : r_g + 1'b1;
                    r_valid    <= 1'b0;
                    r_state    <= w_last ? DONE : ARB;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_out_drain_sched.sv
// tb_out_drain_sched: cycle-by-cycle comparison against a transaction-level
// drain model, plus directed tiles with hand-computed address sequences.
module tb_out_drain_sched;
    localparam int NCOL = 4, DW = 32, AW = 16, WPC = 8;

    logic            clk = 1'b0, rst, start, wr_ready;
    logic [AW-1:0]   base_addr, wr_addr;
    logic [NCOL-1:0] col_rvalid, col_rread;
    logic [DW-1:0]   col_data [NCOL];
    logic [DW-1:0]   wr_data;
    logic            wr_valid, busy, done;

    out_drain_sched #(.NCOL(NCOL), .DW(DW), .AW(AW), .WPC(WPC)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .col_rvalid(col_rvalid), .col_data(col_data), .col_rread(col_rread),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, n_step = 0, n_done = 0, n_rread = 0;
    int done_step = -1, fv_step = -1, t0 = 0;
    // model: phase 0 idle, 1 arbitrate, 2 transfer, 3 done
    int m_st, m_cnt [NCOL], m_rr, m_g, m_total, m_pop;
    logic [AW-1:0] m_base, m_addr;
    logic [DW-1:0] m_data;
    logic m_valid;
    logic [AW-1:0] d_acc [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NCOL; k++) begin
            int c = (m_rr + k) % NCOL;
            if (col_rvalid[c] && m_cnt[c] < WPC) return c;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_st = 0; m_rr = 0; m_g = 0; m_total = 0;
        m_base = '0; m_addr = '0; m_data = '0; m_valid = 1'b0;
        foreach (m_cnt[c]) m_cnt[c] = 0;
    endtask

    task automatic check();
        int g;
        logic [NCOL-1:0] one, exp_rd;
        one = 1;
        g = (m_st == 1) ? pick() : -1;
        exp_rd = (g >= 0) ? one << g : '0;
        chk("col_rread", col_rread, exp_rd);
        chk("wr_valid", wr_valid, m_valid);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("busy", busy, m_st != 0);
        chk("done", done, m_st == 3);
        if (wr_valid && wr_ready && !rst) d_acc.push_back(wr_addr);
        if (wr_valid && fv_step < 0) fv_step = n_step;
        if (done) begin
            n_done++;
            if (done_step < 0) done_step = n_step;
        end
        n_rread += $countones(col_rread);
    endtask

    task automatic model_next();
        int g;
        m_pop = -1;
        if (rst) begin
            m_reset();
            return;
        end
        case (m_st)
            0: if (start) begin
                m_base = base_addr; m_rr = 0; m_total = 0;
                foreach (m_cnt[c]) m_cnt[c] = 0;
                m_st = 1;
            end
            1: begin
                g = pick();
                if (g >= 0) begin
                    m_g = g; m_pop = g; m_data = col_data[g];
                    m_addr = m_base + AW'(g * WPC + m_cnt[g]);
                    m_valid = 1'b1; m_st = 2;
                end
            end
            2: if (wr_ready) begin
                m_cnt[m_g]++; m_total++;
                m_rr = (m_g + 1) % NCOL;
                m_valid = 1'b0;
                m_st = (m_total == NCOL * WPC) ? 3 : 1;
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic step();
        #1;
        if (rst) m_reset();
        check();
        model_next();
        @(posedge clk);
        #1;
        if (m_pop >= 0) col_data[m_pop] = $urandom;
        n_step++;
    endtask

    task automatic begin_tile(input logic [AW-1:0] b);
        d_acc.delete(); n_done = 0; n_rread = 0; done_step = -1; fv_step = -1;
        start = 1'b1; base_addr = b; t0 = n_step;
        step();
        start = 1'b0;
    endtask

    task automatic pad_acc();
        while (d_acc.size() < NCOL * WPC) d_acc.push_back('1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; col_rvalid = '0; wr_ready = 1'b0;
        foreach (col_data[c]) col_data[c] = $urandom;
        m_reset();
        @(posedge clk);
        #1;
        step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", wr_valid, 1'b0);
        rst = 1'b0;

        // full tile, everything ready; a mid-tile start with a new base must be ignored
        col_rvalid = '1; wr_ready = 1'b1;
        begin_tile(16'h0100);
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            start = (i == 10); base_addr = (i == 10) ? 16'h0200 : 16'h0100;
            step();
        end
        start = 1'b0;
        chk("A_count", d_acc.size(), 32);
        pad_acc();
        chk("A_addr0", d_acc[0], 16'h0100);
        chk("A_addr1", d_acc[1], 16'h0108);
        chk("A_addr2", d_acc[2], 16'h0110);
        chk("A_addr3", d_acc[3], 16'h0118);
        chk("A_addr4", d_acc[4], 16'h0101);
        chk("A_addr31", d_acc[31], 16'h011F);
        chk("A_done_cycle", done_step - t0, 65);
        chk("A_latency", fv_step - t0, 2);
        step();
        chk("A_done_once", n_done, 1);

        // only column 2 has data: it drains alone, then the tile waits for the rest
        col_rvalid = 4'b0100;
        begin_tile(16'h0100);
        for (int i = 0; i < 30; i++) step();
        chk("B_count", d_acc.size(), 8);
        pad_acc();
        chk("B_first", d_acc[0], 16'h0110);
        chk("B_last", d_acc[7], 16'h0117);
        chk("B_no_done", n_done, 0);
        chk("B_busy", busy, 1'b1);
        col_rvalid = '1;
        for (int i = 0; i < 100 && n_done == 0; i++) step();
        chk("B_done", n_done, 1);
        step();

        // address wrap, with the sink stalled for the first several transfer cycles
        col_rvalid = 4'b1000; wr_ready = 1'b0;
        begin_tile(16'hFFFC);
        for (int i = 0; i < 25; i++) begin
            wr_ready = (i >= 7);
            step();
        end
        chk("C_count", d_acc.size(), 8);
        pad_acc();
        chk("C_first", d_acc[0], 16'h0014);
        chk("C_wrap", d_acc[7], 16'h001B);
        chk("C_rread_pulses", n_rread, 8);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // asynchronous reset after ten accepted words, then a fresh tile
        col_rvalid = '1; wr_ready = 1'b1;
        begin_tile(16'h0000);
        for (int i = 0; i < 100 && d_acc.size() < 10; i++) step();
        rst = 1'b1;
        #1;
        chk("D_rst_valid", wr_valid, 1'b0);
        chk("D_rst_addr", wr_addr, '0);
        chk("D_rst_data", wr_data, '0);
        chk("D_rst_busy", busy, 1'b0);
        chk("D_rst_rread", col_rread, '0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("D_no_done", n_done, 0);
        begin_tile(16'h0040);
        for (int i = 0; i < 20 && d_acc.size() == 0; i++) step();
        pad_acc();
        chk("D_restart", d_acc[0], 16'h0040);
        for (int i = 0; i < 200 && n_done == 0; i++) step();
        chk("D_done", n_done, 1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            col_rvalid = NCOL'($urandom | $urandom);
            wr_ready = ($urandom % 4) != 0;
            start = ($urandom % 8) == 0;
            base_addr = AW'($urandom);
            rst = ($urandom % 500) == 0;
            step();
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
